// File: rtl/nios2_mul_pkg.sv
// Shared types and constants for the Nios II multiply sequencer.
package nios2_mul_pkg;

  localparam int HALF_W = 16;

  // Operation codes driven by the execute stage.
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULXUU = 2'b01,
    MULXSU = 2'b10,
    MULXSS = 2'b11
  } op_e;

  // Sequencer states: two issue/capture passes, then hold the response.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    CAP1   = 3'd2,
    ISSUE2 = 3'd3,
    CAP2   = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Amount to subtract from the unsigned upper word to get the signed
  // upper word: a negative operand contributes 2^32 times the other one.
  function automatic logic [31:0] sign_correction(input op_e op,
                                                  input logic [31:0] a,
                                                  input logic [31:0] b);
    logic [31:0] corr;
    corr = 32'h0;
    if ((op == MULXSU || op == MULXSS) && a[31]) corr = corr + b;
    if (op == MULXSS && b[31]) corr = corr + a;
    return corr;
  endfunction

endpackage

// File: rtl/nios2_mul_sequencer.sv
// Drives the 16x16 partial-product cell and assembles MUL / MULX* results.
module nios2_mul_sequencer
  import nios2_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [31:0] mc_src1,
  output logic [31:0] mc_src2,
  output logic        mc_en,
  input  logic [31:0] mc_p1,
  input  logic [31:0] mc_p2,
  input  logic [31:0] mc_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result
);

  state_e      state_reg;
  op_e         op_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  // Only the bits of the cross-product sum above the low half are needed
  // for the upper word; the low half is already folded into the carry.
  logic [32-HALF_W:0] mid_hi_reg;
  logic        c_reg;

  logic [32:0] mid_next;
  logic [32:0] lo_next;
  logic [31:0] hi_next;

  // Combine partial products: low word in the first capture, upper word in the second.
  always_comb begin
    mid_next = {1'b0, mc_p2} + {1'b0, mc_p3};
    lo_next  = {1'b0, mc_p1} + {1'b0, mid_next[HALF_W-1:0], {HALF_W{1'b0}}};
    hi_next  = mc_p1 + {{(HALF_W-1){1'b0}}, mid_hi_reg} + {31'h0, c_reg};
    hi_next  = hi_next - sign_correction(op_reg, a_reg, b_reg);
  end

  // Sequencer FSM with registered handshake, cell-drive and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= MUL;
      a_reg      <= 32'h0;
      b_reg      <= 32'h0;
      mid_hi_reg <= '0;
      c_reg      <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'h0;
      mc_en      <= 1'b0;
      mc_src1    <= 32'h0;
      mc_src2    <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg    <= op_e'(req_op);
            a_reg     <= req_src1;
            b_reg     <= req_src2;
            mc_src1   <= req_src1;
            mc_src2   <= req_src2;
            mc_en     <= 1'b1;
            req_ready <= 1'b0;
            state_reg <= ISSUE1;
          end
        end
        ISSUE1: begin
          mc_en     <= 1'b0;
          state_reg <= CAP1;
        end
        CAP1: begin
          if (op_reg == MUL) begin
            rsp_result <= lo_next[31:0];
            rsp_valid  <= 1'b1;
            state_reg  <= DONE;
          end else begin
            mid_hi_reg <= mid_next[32:HALF_W];
            c_reg      <= lo_next[32];
            mc_src1    <= {{HALF_W{1'b0}}, a_reg[31:HALF_W]};
            mc_src2    <= {{HALF_W{1'b0}}, b_reg[31:HALF_W]};
            mc_en      <= 1'b1;
            state_reg  <= ISSUE2;
          end
        end
        ISSUE2: begin
          mc_en     <= 1'b0;
          state_reg <= CAP2;
        end
        CAP2: begin
          rsp_result <= hi_next;
          rsp_valid  <= 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// Bench for nios2_mul_sequencer: behavioural cell, cycle model and scoreboard.
`timescale 1ns/1ps
module tb_nios2_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [31:0] mc_src1;
  logic [31:0] mc_src2;
  logic        mc_en;
  logic [31:0] mc_p1;
  logic [31:0] mc_p2;
  logic [31:0] mc_p3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        reset_n;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  bit chk_en = 1'b0;

  nios2_mul_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .mc_src1(mc_src1), .mc_src2(mc_src2), .mc_en(mc_en),
    .mc_p1(mc_p1), .mc_p2(mc_p2), .mc_p3(mc_p3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier cell: registers partial products when enabled.
  assign reset_n = ~reset;
  always @(posedge clk) begin
    if (!reset_n) begin
      mc_p1 <= 32'h0; mc_p2 <= 32'h0; mc_p3 <= 32'h0;
    end else if (mc_en) begin
      mc_p1 <= {16'h0, mc_src1[15:0]}  * {16'h0, mc_src2[15:0]};
      mc_p2 <= {16'h0, mc_src1[15:0]}  * {16'h0, mc_src2[31:16]};
      mc_p3 <= {16'h0, mc_src1[31:16]} * {16'h0, mc_src2[15:0]};
    end
  end

  // 64-bit reference product.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = ((op == 2'b10 || op == 2'b11) && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    xb = (op == 2'b11 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy flag, cycle index since accept, expected result.
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 3;
  logic [1:0]  m_op = 2'b00;
  logic [31:0] m_a = 32'h0;
  logic [31:0] m_res = 32'h0;
  logic [31:0] m_src1 = 32'h0;
  logic [31:0] m_src2 = 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_cnt = 0; m_src1 = 32'h0; m_src2 = 32'h0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1; m_cnt = 1; m_op = req_op; m_a = req_src1;
        m_lat  = (req_op == 2'b00) ? 3 : 5;
        m_res  = ref_mul(req_op, req_src1, req_src2);
        m_src1 = req_src1; m_src2 = req_src2;
      end
    end else if (m_cnt >= m_lat) begin
      if (rsp_ready) m_busy = 1'b0;
    end else begin
      m_cnt++;
      if (m_op != 2'b00 && m_cnt == 3) begin
        m_src1 = {16'h0, m_a[31:16]};
        m_src2 = {16'h0, m_src2[31:16]};
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_req_ready", {31'h0, req_ready}, {31'h0, !m_busy});
      chk("cyc_rsp_valid", {31'h0, rsp_valid}, {31'h0, m_busy && m_cnt >= m_lat});
      chk("cyc_mc_en", {31'h0, mc_en},
          {31'h0, m_busy && (m_cnt == 1 || (m_op != 2'b00 && m_cnt == 3))});
      chk("cyc_mc_src1", mc_src1, m_src1);
      chk("cyc_mc_src2", mc_src2, m_src2);
      if (m_busy && m_cnt >= m_lat) chk("cyc_rsp_result", rsp_result, m_res);
    end
  end

  always @(negedge clk) if (mc_en) en_cnt++;

  // One request/response transaction with literal expectations.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int hold, input bit verbose);
    int cyc, lat, guard, en_start;
    lat = (op == 2'b00) ? 3 : 5;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("accept_timeout", {31'h0, guard >= 50}, 32'h0);
    en_start = en_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_src1 = $urandom; req_src2 = $urandom;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk); cyc++;
      if (rsp_valid) break;
    end
    chk("latency", cyc, lat);
    chk("result", rsp_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold_result", rsp_result, exp);
      chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("release_req_ready", {31'h0, req_ready}, 32'h1);
    chk("release_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("en_pulses", en_cnt - en_start, (op == 2'b00) ? 1 : 2);
    if (verbose)
      $display("op=%0d a=%h b=%h result=%h latency=%0d", op, a, b, rsp_result, cyc);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00;
    req_src1 = 32'h0; req_src2 = 32'h0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_mc_en", {31'h0, mc_en}, 32'h0);
    chk("rst_mc_src1", mc_src1, 32'h0);
    chk("rst_mc_src2", mc_src2, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_op(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0, 1'b1);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b1);
    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b1);
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
    do_op(2'b11, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1'b1);
    do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 4, 1'b1);

    // Reset during the first capture of a MULXUU.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'hFFFF_FFFF; req_src2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("midrst_mc_en", {31'h0, mc_en}, 32'h0);
    chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("midrst_rsp_result", rsp_result, 32'h0);
    chk("midrst_mc_src1", mc_src1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    $display("reset mid-operation: returned to idle, no response");
    do_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, 0, 1'b1);

    // Randomized traffic with request gaps and response backpressure.
    for (int n = 0; n < 4000; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(op, a, b, ref_mul(op, a, b), $urandom_range(0, 2), 1'b0);
    end
    $display("random: 4000 transactions issued");

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
